// File: rtl/ofs_plat_prim_lutram_fifo.sv
// Single-clock FIFO over an MLAB LUTRAM with async read; owns both pointers and
// registered occupancy flags so callers only see enq/deq handshakes.

module ofs_plat_prim_lutram_fifo #(
  parameter int N_ENTRIES     = 32,
  parameter int N_DATA_BITS   = 64,
  parameter int THRESHOLD     = 2,
  parameter bit ENABLE_CHECKS = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_DATA_BITS-1:0]       enq_data,
  input  logic                         enq_en,
  output logic                         notFull,
  output logic                         almostFull,
  output logic [N_DATA_BITS-1:0]       first,
  input  logic                         deq_en,
  output logic                         notEmpty,
  output logic [$clog2(N_ENTRIES):0]   count
);

  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  // A 1-bit wide LUTRAM would be mapped to registers, so pad it to 2 bits.
  localparam int RAM_W = (N_DATA_BITS == 1) ? 2 : N_DATA_BITS;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ENTRIES);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(N_ENTRIES - THRESHOLD);

  logic [RAM_W-1:0] ram_r [N_ENTRIES];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             not_empty_r;
  logic             not_full_r;
  logic             almost_full_r;
  logic             push_acc_s;
  logic             pop_acc_s;
  logic [RAM_W-1:0] wr_word_s;

  // Handshake acceptance and next occupancy.
  always_comb begin
    push_acc_s = enq_en && not_full_r;
    pop_acc_s  = deq_en && not_empty_r;
    wr_word_s  = RAM_W'(enq_data);
    case ({push_acc_s, pop_acc_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and flags; flags come from the next count so they stay registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      not_empty_r   <= 1'b0;
      not_full_r    <= 1'b1;
      almost_full_r <= 1'b0;
    end else begin
      if (push_acc_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_acc_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r       <= count_next_s;
      not_empty_r   <= (count_next_s != '0);
      not_full_r    <= (count_next_s != CNT_FULL);
      almost_full_r <= (count_next_s >= CNT_AF);
    end
  end

  // Storage write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (push_acc_s && !reset) ram_r[wr_ptr_r] <= wr_word_s;
  end

  assign first      = ram_r[rd_ptr_r][N_DATA_BITS-1:0];
  assign notEmpty   = not_empty_r;
  assign notFull    = not_full_r;
  assign almostFull = almost_full_r;
  assign count      = count_r;

  generate
    if (ENABLE_CHECKS) begin : g_chk
      ofs_plat_prim_lutram_fifo_chk #(.N_ENTRIES(N_ENTRIES)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .enq_en   (enq_en),
        .deq_en   (deq_en),
        .notFull  (notFull),
        .notEmpty (notEmpty),
        .count    (count)
      );
    end
  endgenerate

endmodule

// Protocol checker: flags pushes into a full FIFO and pops from an empty one.
module ofs_plat_prim_lutram_fifo_chk #(
  parameter int N_ENTRIES = 32
) (
  input logic                       clk,
  input logic                       reset,
  input logic                       enq_en,
  input logic                       deq_en,
  input logic                       notFull,
  input logic                       notEmpty,
  input logic [$clog2(N_ENTRIES):0] count
);

  localparam logic [$clog2(N_ENTRIES):0] CNT_FULL = ($clog2(N_ENTRIES)+1)'(N_ENTRIES);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset) enq_en |-> notFull)
    else $error("lutram_fifo: enq_en while full");
  a_no_pop_when_empty: assert property (@(posedge clk) disable iff (reset) deq_en |-> notEmpty)
    else $error("lutram_fifo: deq_en while empty");
  a_count_range: assert property (@(posedge clk) disable iff (reset) count <= CNT_FULL)
    else $error("lutram_fifo: count out of range");

endmodule

// File: tb/tb_ofs_plat_prim_lutram_fifo.sv
// Directed + random bench: a 4x8 FIFO for protocol corner cases and an 8x1 FIFO
// with protocol checks enabled for a long random run against a queue scoreboard.

module tb_ofs_plat_prim_lutram_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_ENTRIES=4, N_DATA_BITS=8, THRESHOLD=1
  logic       a_reset, a_enq_en, a_deq_en;
  logic [7:0] a_enq_data, a_first;
  logic       a_notFull, a_almostFull, a_notEmpty;
  logic [2:0] a_count;

  // Instance B: N_ENTRIES=8, N_DATA_BITS=1, THRESHOLD=2
  logic       b_reset, b_enq_en, b_deq_en;
  logic [0:0] b_enq_data, b_first;
  logic       b_notFull, b_almostFull, b_notEmpty;
  logic [3:0] b_count;

  ofs_plat_prim_lutram_fifo #(.N_ENTRIES(4), .N_DATA_BITS(8), .THRESHOLD(1), .ENABLE_CHECKS(1'b0)) dut_a (
    .clk(clk), .reset(a_reset), .enq_data(a_enq_data), .enq_en(a_enq_en), .notFull(a_notFull),
    .almostFull(a_almostFull), .first(a_first), .deq_en(a_deq_en), .notEmpty(a_notEmpty), .count(a_count)
  );

  ofs_plat_prim_lutram_fifo #(.N_ENTRIES(8), .N_DATA_BITS(1), .THRESHOLD(2), .ENABLE_CHECKS(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .enq_data(b_enq_data), .enq_en(b_enq_en), .notFull(b_notFull),
    .almostFull(b_almostFull), .first(b_first), .deq_en(b_deq_en), .notEmpty(b_notEmpty), .count(b_count)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q_a[$];
  logic       q_b[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_flags(input string tag);
    chk({tag, " count"}, 32'(a_count), 32'(q_a.size()));
    chk({tag, " notEmpty"}, 32'(a_notEmpty), 32'(q_a.size() != 0));
    chk({tag, " notFull"}, 32'(a_notFull), 32'(q_a.size() != 4));
    chk({tag, " almostFull"}, 32'(a_almostFull), 32'((4 - q_a.size()) <= 1));
    if (q_a.size() > 0) chk({tag, " first"}, 32'(a_first), 32'(q_a[0]));
  endtask

  task automatic b_flags(input string tag);
    chk({tag, " count"}, 32'(b_count), 32'(q_b.size()));
    chk({tag, " notEmpty"}, 32'(b_notEmpty), 32'(q_b.size() != 0));
    chk({tag, " notFull"}, 32'(b_notFull), 32'(q_b.size() != 8));
    chk({tag, " almostFull"}, 32'(b_almostFull), 32'((8 - q_b.size()) <= 2));
    if (q_b.size() > 0) chk({tag, " first"}, 32'(b_first), 32'(q_b[0]));
  endtask

  // One clock on instance A; the scoreboard decides acceptance from its own occupancy.
  task automatic a_cyc(input logic en, input logic [7:0] d, input logic de, input string tag);
    bit push_ok, pop_ok;
    logic [7:0] exp_pop;
    push_ok = en && (q_a.size() < 4);
    pop_ok  = de && (q_a.size() > 0);
    a_enq_en = en; a_enq_data = d; a_deq_en = de;
    if (pop_ok) chk({tag, " pop"}, 32'(a_first), 32'(q_a[0]));
    @(posedge clk); #1;
    if (pop_ok) exp_pop = q_a.pop_front();
    if (push_ok) q_a.push_back(d);
    a_enq_en = 1'b0; a_deq_en = 1'b0;
    a_flags(tag);
  endtask

  task automatic b_cyc(input logic en, input logic d, input logic de, input string tag);
    bit push_ok, pop_ok;
    logic exp_pop;
    push_ok = en && (q_b.size() < 8);
    pop_ok  = de && (q_b.size() > 0);
    b_enq_en = en; b_enq_data = d; b_deq_en = de;
    if (pop_ok) chk({tag, " pop"}, 32'(b_first), 32'(q_b[0]));
    @(posedge clk); #1;
    if (pop_ok) exp_pop = q_b.pop_front();
    if (push_ok) q_b.push_back(d);
    b_enq_en = 1'b0; b_deq_en = 1'b0;
    b_flags(tag);
  endtask

  task automatic a_reset_cyc(input logic en, input string tag);
    a_reset = 1'b1; a_enq_en = en; a_enq_data = 8'hEE; a_deq_en = 1'b0;
    @(posedge clk); #1;
    a_reset = 1'b0; a_enq_en = 1'b0;
    q_a.delete();
    a_flags(tag);
  endtask

  initial begin
    a_reset = 1'b1; a_enq_en = 1'b0; a_deq_en = 1'b0; a_enq_data = 8'h00;
    b_reset = 1'b1; b_enq_en = 1'b0; b_deq_en = 1'b0; b_enq_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0; b_reset = 1'b0;
    a_flags("reset_a");
    b_flags("reset_b");

    // 1: first push visible one cycle later
    a_cyc(1'b1, 8'h11, 1'b0, "t1_push");
    a_cyc(1'b0, 8'h00, 1'b1, "t1_pop");

    // 2: fill, overflow push dropped, drain in order
    a_reset_cyc(1'b0, "t2_reset");
    for (int i = 0; i < 4; i++) a_cyc(1'b1, 8'hA0 + 8'(i), 1'b0, "t2_fill");
    a_cyc(1'b1, 8'hFF, 1'b0, "t2_overflow");
    for (int i = 0; i < 4; i++) a_cyc(1'b0, 8'h00, 1'b1, "t2_drain");

    // 3: steady state at count 2, pointers wrap repeatedly
    a_reset_cyc(1'b0, "t3_reset");
    a_cyc(1'b1, 8'h00, 1'b0, "t3_prime");
    a_cyc(1'b1, 8'h01, 1'b0, "t3_prime");
    for (int i = 0; i < 20; i++) a_cyc(1'b1, 8'(i + 2), 1'b1, "t3_stream");

    // 4: simultaneous push/pop at full and at empty
    a_reset_cyc(1'b0, "t4_reset");
    for (int i = 0; i < 4; i++) a_cyc(1'b1, 8'hC0 + 8'(i), 1'b0, "t4_fill");
    a_cyc(1'b1, 8'hDD, 1'b1, "t4_full_pushpop");
    for (int i = 0; i < 3; i++) a_cyc(1'b0, 8'h00, 1'b1, "t4_drain");
    a_cyc(1'b1, 8'h77, 1'b1, "t4_empty_pushpop");
    a_cyc(1'b0, 8'h00, 1'b1, "t4_final_pop");

    // 5: reset with entries held and a push pending
    for (int i = 0; i < 3; i++) a_cyc(1'b1, 8'h30 + 8'(i), 1'b0, "t5_fill");
    a_reset_cyc(1'b1, "t5_midreset");
    a_cyc(1'b1, 8'h5A, 1'b0, "t5_push");
    a_cyc(1'b0, 8'h00, 1'b1, "t5_pop");

    // 6: 1-bit payload, directed then random with protocol checks live
    b_cyc(1'b1, 1'b1, 1'b0, "t6_push");
    b_cyc(1'b1, 1'b0, 1'b0, "t6_push");
    b_cyc(1'b1, 1'b1, 1'b0, "t6_push");
    b_cyc(1'b1, 1'b1, 1'b0, "t6_push");
    for (int i = 0; i < 4; i++) b_cyc(1'b0, 1'b0, 1'b1, "t6_pop");
    for (int i = 0; i < 10000; i++) begin
      logic en, de, d;
      en = ($urandom_range(0, 1) == 1) && (q_b.size() < 8);
      de = ($urandom_range(0, 1) == 1) && (q_b.size() > 0);
      d  = 1'($urandom_range(0, 1));
      b_cyc(en, d, de, "t6_random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
